// File: rtl/sem_channel_pkg.sv
// rtl/sem_channel_pkg.sv - shared defaults for the semaphore channel (SEM_CHAN_ERR_EN selects error flags)
`ifndef DATA_WIDTH
`define DATA_WIDTH 1
`endif
`ifndef SEM_PTR_W
`define SEM_PTR_W(d) $clog2(d)
`endif

package sem_channel_pkg;
    localparam int   SEM_DEPTH    = 4;
    localparam logic SEM_FLAG_RST = 1'b0;
endpackage

// File: rtl/sem_fifo_mem.sv
// rtl/sem_fifo_mem.sv - DEPTH x DATA_WIDTH register array, one write port, one async read port
module sem_fifo_mem #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // No reset: contents are only observable through valid slots.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sem_channel.sv
// rtl/sem_channel.sv - producer/consumer semaphore FIFO channel; SEM_CHAN_ERR_EN enables sticky overflow/underflow
module sem_channel
    import sem_channel_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = SEM_DEPTH,
    parameter int PTR_WIDTH  = `SEM_PTR_W(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_empty,
    output logic                  prod_full,
    output logic [DATA_WIDTH-1:0] cons_data,
    output logic                  cons_valid,
    input  logic                  cons_read,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  full, push_acc, pop_acc;

    assign full       = (count_q == FULL_CNT);
    assign prod_empty = (count_q == '0);
    assign prod_full  = full;
    assign cons_valid = !prod_empty;
    assign count      = count_q;

    // A pop frees the slot the same cycle, so a full channel still accepts a push.
    assign pop_acc  = cons_read && !prod_empty;
    assign push_acc = prod_valid && (!full || pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sem_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr_q),
        .wdata (prod_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign cons_data = cons_valid ? mem_rdata : '0;

`ifdef SEM_CHAN_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (prod_valid && full && !pop_acc);
        underflow_d = underflow_q | (cons_read && prod_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= SEM_FLAG_RST;
            underflow_q <= SEM_FLAG_RST;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = SEM_FLAG_RST;
    assign underflow = SEM_FLAG_RST;
`endif
endmodule

// File: tb/tb_sem_channel.sv
// tb/tb_sem_channel.sv - directed self-checking bench for sem_channel
module tb_sem_channel;
`ifdef SEM_CHAN_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] prod_data;
    logic       prod_valid;
    logic       prod_empty;
    logic       prod_full;
    logic [0:0] cons_data;
    logic       cons_valid;
    logic       cons_read;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    sem_channel #(.DATA_WIDTH(1), .DEPTH(4), .PTR_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_empty (prod_empty),
        .prod_full  (prod_full),
        .cons_data  (cons_data),
        .cons_valid (cons_valid),
        .cons_read  (cons_read),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d);
        prod_data  = d;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic d);
        check(tag, cons_data, d);
        cons_read = 1'b1;
        tick();
        cons_read = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        prod_data  = '0;
        prod_valid = 1'b0;
        cons_read  = 1'b0;
        #2;
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_empty", prod_empty, 1);
        check("idle_valid", cons_valid, 0);
        check("idle_count", count, 0);
        check("idle_data", cons_data, 0);
        check("idle_full", prod_full, 0);
        check("idle_ovf", overflow, 0);
        check("idle_udf", underflow, 0);

        push(1'b1);
        check("single_valid", cons_valid, 1);
        check("single_data", cons_data, 1);
        check("single_count", count, 1);
        check("single_empty", prod_empty, 0);
        pop_expect("single_head", 1'b1);
        check("single_pop_count", count, 0);
        check("single_pop_empty", prod_empty, 1);
        check("single_pop_data", cons_data, 0);

        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        check("fill_full", prod_full, 1);
        check("fill_count", count, 4);
        pop_expect("order0", 1'b1);
        pop_expect("order1", 1'b0);
        pop_expect("order2", 1'b1);
        pop_expect("order3", 1'b1);
        check("drain_count", count, 0);

        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        push(1'b0);
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, ERR_EN);
        check("ovf_head", cons_data, 1);

        prod_data  = 1'b0;
        prod_valid = 1'b1;
        cons_read  = 1'b1;
        tick();
        prod_valid = 1'b0;
        cons_read  = 1'b0;
        check("simul_count", count, 4);
        check("simul_full", prod_full, 1);
        check("simul_ovf", overflow, ERR_EN);
        pop_expect("simul0", 1'b0);
        pop_expect("simul1", 1'b1);
        pop_expect("simul2", 1'b1);
        pop_expect("simul3", 1'b0);
        check("simul_drain", count, 0);

        cons_read = 1'b1;
        tick();
        cons_read = 1'b0;
        check("udf_flag", underflow, ERR_EN);
        check("udf_count", count, 0);

        prod_data  = 1'b1;
        prod_valid = 1'b1;
        cons_read  = 1'b1;
        tick();
        prod_valid = 1'b0;
        cons_read  = 1'b0;
        check("empty_simul_count", count, 1);
        check("empty_simul_data", cons_data, 1);
        push(1'b0);
        check("pre_rst_count", count, 2);

        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", cons_valid, 0);
        check("mid_rst_empty", prod_empty, 1);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_udf", underflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
